// File: rtl/snd_arbiter.sv
// ---------------------------------------------------------------------------
// snd_arbiter
//   Shares the single sound manager (sndm) among NREQ requesters. Each
//   requester posts a one-cycle request with a 3-bit mode. The request is
//   held in a per-requester pending slot. Slots are granted by fixed
//   priority, with index 0 highest. The arbiter drives the sndm mode/trigger
//   pair, then follows snd_playing to decide when the next sound may start.
//
// Optional feature (compile-time macro SND_ARB_PREEMPT_EN):
//   When defined, a pending request with a lower index than the current
//   grant aborts the sound during WAIT_START/PLAY and is triggered at once.
//   When undefined, no preemption takes place.
//
// Ports:
//   clk_1mhz     in   system clock
//   rst          in   synchronous, active-high reset
//   req_valid    in   [NREQ]    one-cycle request pulse per requester
//   req_mode     in   [3*NREQ]  mode of requester i in bits [3i+2:3i]
//   flush        in   one-cycle pulse, discards all pending requests
//   snd_playing  in   playing flag from sndm
//   snd_mode     out  [3]       mode presented to sndm
//   snd_trig     out  one-cycle trigger to sndm
//   grant_id     out  [IW]      requester currently or last served
//   done         out  one-cycle pulse when a granted sound finishes
//   req_ovr      out  [NREQ]    a new request overwrote an unserved one
//   busy         out  state != IDLE or any request pending
// ---------------------------------------------------------------------------
module snd_arbiter #(
    parameter int NREQ     = 4,
    parameter int GAP_CYC  = 1000,
    parameter int START_TO = 16
) (
    input  logic                                clk_1mhz,
    input  logic                                rst,
    input  logic [NREQ-1:0]                     req_valid,
    input  logic [3*NREQ-1:0]                   req_mode,
    input  logic                                flush,
    input  logic                                snd_playing,
    output logic [2:0]                          snd_mode,
    output logic                                snd_trig,
    output logic [(NREQ > 1 ? $clog2(NREQ) : 1)-1:0] grant_id,
    output logic                                done,
    output logic [NREQ-1:0]                     req_ovr,
    output logic                                busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (START_TO > 1) ? $clog2(START_TO) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    // Terminal counts. With GAP_CYC of 0 or 1 the terminal value is 0,
    // so GAP is left on its first cycle.
    localparam logic [TW-1:0] TO_LAST  = TW'((START_TO > 0) ? START_TO - 1 : 0);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 1) ? GAP_CYC - 1 : 0);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TRIG = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_PLAY = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    logic [2:0]      state;
    logic [NREQ-1:0] pend;
    logic [2:0]      pmode [NREQ];
    logic [TW-1:0]   to_cnt;
    logic [GW-1:0]   gap_cnt;

    logic            win_vld;
    logic [IW-1:0]   win_idx;
    logic            grant_en;
    logic [NREQ-1:0] grant_vec;

    // Fixed-priority pick. The loop scans downward, so the lowest set
    // index is written last and wins.
    always_comb begin
        win_vld   = |pend;
        win_idx   = '0;
        grant_en  = 1'b0;
        grant_vec = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pend[i]) win_idx = IW'(i);
        end
        // A flush on the same edge wins over any grant, so nothing it
        // discards can slip through.
        if (win_vld && !flush) begin
            if (state == S_IDLE) begin
                grant_en = 1'b1;
            end
`ifdef SND_ARB_PREEMPT_EN
            else if ((state == S_WAIT || state == S_PLAY) && (win_idx < grant_id)) begin
                grant_en = 1'b1;
            end
`endif
        end
        if (grant_en) grant_vec[win_idx] = 1'b1;
    end

    // Pending flags. If a request arrives on the same edge that its slot
    // is granted, the old entry is served and the new one stays pending
    // without being reported as an overwrite.
    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            pend    <= '0;
            req_ovr <= '0;
        end else begin
            req_ovr <= '0;
            for (int i = 0; i < NREQ; i++) begin
                if (flush) begin
                    pend[i] <= 1'b0;
                end else if (req_valid[i]) begin
                    pend[i] <= 1'b1;
                    if (pend[i] && !grant_vec[i]) req_ovr[i] <= 1'b1;
                end else if (grant_vec[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    // Pending modes are data qualified by pend, so they need no reset.
    always_ff @(posedge clk_1mhz) begin
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && !flush) pmode[i] <= req_mode[3*i +: 3];
        end
    end

    // Grant and playback tracking. snd_trig is registered from the TRIG
    // state, so the trigger fires one cycle after TRIG is entered while
    // snd_mode is already stable.
    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            state    <= S_IDLE;
            snd_mode <= '0;
            grant_id <= '0;
            snd_trig <= 1'b0;
            done     <= 1'b0;
            to_cnt   <= '0;
            gap_cnt  <= '0;
        end else begin
            snd_trig <= (state == S_TRIG);
            done     <= 1'b0;
            if (grant_en) begin
                snd_mode <= pmode[win_idx];
                grant_id <= win_idx;
                state    <= S_TRIG;
                // A grant outside IDLE is a preemption: close out the
                // aborted sound.
                if (state != S_IDLE) done <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: state <= S_IDLE;
                    S_TRIG: begin
                        state  <= S_WAIT;
                        to_cnt <= '0;
                    end
                    S_WAIT: begin
                        if (snd_playing) begin
                            state <= S_PLAY;
                        end else if (to_cnt == TO_LAST) begin
                            // sndm never started; treat the sound as finished.
                            done    <= 1'b1;
                            state   <= S_GAP;
                            gap_cnt <= '0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    S_PLAY: begin
                        if (!snd_playing) begin
                            done    <= 1'b1;
                            state   <= S_GAP;
                            gap_cnt <= '0;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == GAP_LAST) state <= S_IDLE;
                        else gap_cnt <= gap_cnt + 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy = (state != S_IDLE) || (|pend);

endmodule
